// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared constants and helpers for the 7-segment scan path.
package seg_scan_driver_pkg;
    localparam int DIGITS = 4;
    localparam logic [3:0] BLANK_AN = 4'b1111;
    localparam logic [2:0] CH_A = 3'b000;
    localparam logic [2:0] CH_5 = 3'b001;
    localparam logic [2:0] CH_C = 3'b010;
    localparam logic [2:0] CH_8 = 3'b011;
    localparam logic [2:0] CH_9 = 3'b100;

    function automatic logic [3:0] digit_an(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: modulo-DIV counter with a one-cycle tick on the wrap cycle.
module seg_tick_gen #(
    parameter int DIV = 4,
    parameter int CW = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);
    always_comb tick = en && cnt == CW'(DIV - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: message buffer scanned across four common-anode digits with optional scrolling.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 16384,
    parameter int GUARD = 2,
    parameter int SCROLL_DIV = 2**24,
    parameter int MSG_LEN = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       msg_wr_en,
    input  logic [2:0]                 msg_wr_data,
    input  logic                       msg_clear,
    input  logic                       scroll_en,
    output logic [2:0]                 char,
    output logic [3:0]                 an,
    output logic [$clog2(MSG_LEN):0]   msg_count
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam logic [AW:0] FULL = (AW+1)'(MSG_LEN);
    localparam logic [AW:0] FOUR = (AW+1)'(DIGITS);

    logic [2:0]    msg_buf [MSG_LEN];
    logic [AW-1:0] wr_ptr, offset, idx;
    logic [AW:0]   pos, sum;
    logic [1:0]    digit_sel, dig_nxt;
    logic [RW-1:0] refresh_cnt;
    logic [SW-1:0] scroll_cnt_unused;
    logic          r_tick, s_tick, guard_n, blank_sel, vis, vis_n;
    logic [2:0]    ch_sel;

    seg_tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .cnt(refresh_cnt), .tick(r_tick)
    );

    seg_tick_gen #(.DIV(SCROLL_DIV)) u_scroll (
        .clk(clk), .reset(reset), .en(scroll_en), .clr(msg_clear), .cnt(scroll_cnt_unused), .tick(s_tick)
    );

    // Outputs are computed from the upcoming slot state so they line up with refresh_cnt.
    always_comb begin
        dig_nxt = digit_sel + {1'b0, r_tick};
        guard_n = (r_tick ? '0 : refresh_cnt + 1'b1) < RW'(GUARD);
        pos = {{(AW-1){1'b0}}, 2'd3 - dig_nxt};
        sum = {1'b0, offset} + pos;
        idx = AW'(sum >= msg_count ? sum - msg_count : sum);
        blank_sel = pos >= msg_count;
        ch_sel = blank_sel ? CH_A : msg_buf[idx];
        vis_n = !msg_clear && (r_tick ? !blank_sel : vis);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel <= '0;
            wr_ptr <= '0;
            offset <= '0;
            msg_count <= '0;
            char <= CH_A;
            an <= BLANK_AN;
            vis <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= '0;
        end else begin
            digit_sel <= dig_nxt;
            char <= msg_clear ? CH_A : r_tick ? ch_sel : char;
            vis <= vis_n;
            an <= (guard_n || !vis_n) ? BLANK_AN : digit_an(dig_nxt);
            if (msg_clear) begin
                wr_ptr <= '0;
                msg_count <= '0;
                offset <= '0;
            end else begin
                if (msg_wr_en) begin
                    msg_buf[wr_ptr] <= msg_wr_data;
                    wr_ptr <= wr_ptr + 1'b1;
                    if (msg_count != FULL) msg_count <= msg_count + 1'b1;
                end
                if (s_tick)
                    offset <= (msg_count <= FOUR || {1'b0, offset} + 1'b1 == msg_count) ? '0 : offset + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scan/scroll/clear/reset checks against a slot scoreboard.
module tb_seg_scan_driver;
    import seg_scan_driver_pkg::*;

    typedef struct packed {
        logic [3:0] an;
        logic [2:0] ch;
    } slot_t;

    logic       clk = 0, reset = 0, msg_wr_en = 0, msg_clear = 0, scroll_en = 0;
    logic [2:0] msg_wr_data = '0;
    logic [2:0] char;
    logic [3:0] an;
    logic [3:0] msg_count;
    int         cyc, n_tests = 0, n_fail = 0;
    slot_t      sb[$];

    seg_scan_driver #(.REFRESH_DIV(4), .GUARD(1), .SCROLL_DIV(32), .MSG_LEN(8)) dut (
        .clk(clk), .reset(reset), .msg_wr_en(msg_wr_en), .msg_wr_data(msg_wr_data),
        .msg_clear(msg_clear), .scroll_en(scroll_en), .char(char), .an(an), .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] c);
        msg_wr_data = c;
        msg_wr_en = 1;
        @(negedge clk);
        msg_wr_en = 0;
    endtask

    task automatic clr();
        msg_clear = 1;
        @(negedge clk);
        msg_clear = 0;
    endtask

    // l0 is the leftmost character; positions at or beyond cnt are blank.
    task automatic push4(input logic [2:0] l0, l1, l2, l3, input int cnt);
        logic [2:0] l[4];
        l = '{l0, l1, l2, l3};
        for (int d = 0; d < 4; d++)
            sb.push_back((3 - d) < cnt ? slot_t'{~(4'b0001 << d), l[3-d]} : slot_t'{4'b1111, 3'b000});
    endtask

    task automatic check_scan(input string name);
        slot_t e;
        @(negedge clk);
        for (int i = 0; i < 16 && cyc % 16 != 0; i++) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            e = sb.size() > 0 ? sb.pop_front() : '1;
            chk($sformatf("%s_guard_d%0d", name, d), {1'b0, an, char}, {1'b0, 4'b1111, e.ch});
            repeat (2) @(negedge clk);
            chk($sformatf("%s_lit_d%0d", name, d), {1'b0, an, char}, {1'b0, e.an, e.ch});
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic scroll_steps(input int n);
        scroll_en = 1;
        repeat (32 * n) @(negedge clk);
        scroll_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {1'b0, an, char}, {1'b0, 4'b1111, 3'b000});
        chk("reset_count", {4'b0, msg_count}, 8'd0);
        reset = 1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("idle_blank", {1'b0, an, char}, {1'b0, 4'b1111, 3'b000});
        end
        chk("idle_count", {4'b0, msg_count}, 8'd0);

        wr(CH_A); wr(CH_5); wr(CH_C); wr(CH_8);
        chk("four_count", {4'b0, msg_count}, 8'd4);
        push4(CH_A, CH_5, CH_C, CH_8, 4);
        check_scan("four");

        clr();
        wr(CH_8); wr(CH_9);
        chk("two_count", {4'b0, msg_count}, 8'd2);
        push4(CH_8, CH_9, CH_A, CH_A, 2);
        check_scan("two");

        clr();
        wr(CH_A); wr(CH_5); wr(CH_C); wr(CH_8); wr(CH_9); wr(CH_A);
        chk("six_count", {4'b0, msg_count}, 8'd6);
        push4(CH_A, CH_5, CH_C, CH_8, 6);
        check_scan("six_off0");
        scroll_steps(1);
        push4(CH_5, CH_C, CH_8, CH_9, 6);
        check_scan("six_off1");
        scroll_steps(4);
        push4(CH_A, CH_A, CH_5, CH_C, 6);
        check_scan("six_off5");
        scroll_steps(1);
        push4(CH_A, CH_5, CH_C, CH_8, 6);
        check_scan("six_wrap");

        clr();
        wr(CH_5); wr(CH_C); wr(CH_8); wr(CH_9); wr(CH_A); wr(CH_5); wr(CH_C); wr(CH_8);
        wr(3'b111); wr(3'b101);
        chk("full_count", {4'b0, msg_count}, 8'd8);
        push4(3'b111, 3'b101, CH_8, CH_9, 8);
        check_scan("full_off0");
        scroll_steps(1);
        push4(3'b101, CH_8, CH_9, CH_A, 8);
        check_scan("full_off1");

        scroll_en = 1;
        repeat (40) @(negedge clk);
        chk("midscroll_offset", {5'b0, dut.offset}, 8'd2);
        msg_clear = 1;
        msg_wr_en = 1;
        msg_wr_data = CH_9;
        @(negedge clk);
        msg_clear = 0;
        msg_wr_en = 0;
        chk("clear_count", {4'b0, msg_count}, 8'd0);
        chk("clear_offset", {5'b0, dut.offset}, 8'd0);
        chk("clear_outputs", {1'b0, an, char}, {1'b0, 4'b1111, 3'b000});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("cleared_blank", {4'b0, an}, 8'h0f);
        end
        scroll_en = 0;

        wr(CH_8);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 16 && cyc % 16 != 14; i++) @(negedge clk);
        chk("prereset_lit", {1'b0, an, char}, {1'b0, 4'b0111, CH_8});
        #2 reset = 0;
        #1;
        chk("async_reset_outputs", {1'b0, an, char}, {1'b0, 4'b1111, 3'b000});
        chk("async_reset_count", {4'b0, msg_count}, 8'd0);
        @(negedge clk);
        reset = 1;
        push4(CH_A, CH_A, CH_A, CH_A, 0);
        check_scan("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
